// File: rtl/fb_pkg.sv
// Shared framebuffer constants: screen geometry, palette, write-buffer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

    localparam int SCREEN_W = 128;
    localparam int SCREEN_H = 96;
    localparam int NPIX     = SCREEN_W * SCREEN_H;

    localparam logic [2:0] COLOR_BARRA = 3'b111;
    localparam logic [2:0] COLOR_BOLA  = 3'b110;
    localparam logic [2:0] COLOR_FONDO = 3'b000;
    localparam logic [2:0] COLOR_LOST  = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_WAIT = 2'd1,
        CLR_RUN  = 2'd2
    } px_state_e;

endpackage

// File: rtl/px_fifo.sv
// Synchronous FIFO of packed {addr,data} pixel writes.
// Latency: head visible combinationally one edge after push; no bypass.
// Backpressure: push while full and pop while empty are ignored.
module px_fifo #(
    parameter int W          = 18,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          push_dat,
    input  logic                  pop,
    output logic [W-1:0]          pop_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    push_ok;
    logic                    pop_ok;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/px_write_buffer.sv
// Pixel write buffer with full-screen clear engine feeding the framebuffer port.
// Latency: queued write reaches mem_wr one granted edge after its push at the earliest.
// Backpressure: writes offered while in_full are dropped and latch ovf; output advances only on mem_en.
module px_write_buffer #(
    parameter int AW         = 15,
    parameter int DW         = 3,
    parameter int DEPTH_LOG2 = 4,
    parameter int NPIX       = fb_pkg::NPIX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         in_addr,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_wr,
    output logic                  in_full,
    output logic                  ovf,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  clr_req,
    input  logic [DW-1:0]         clr_color,
    output logic                  clr_busy,
    input  logic                  mem_en,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_data,
    output logic                  mem_wr
);

    import fb_pkg::*;

    localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int EW = AW + DW;

    px_state_e              state;
    px_state_e              state_nxt;
    logic [CW-1:0]          clr_cnt;
    logic [CW-1:0]          clr_cnt_nxt;
    logic [DEPTH_LOG2:0]    pend;
    logic [DEPTH_LOG2:0]    pend_nxt;
    logic [DW-1:0]          clr_col;
    logic                   latch_col;

    logic                   fifo_pop;
    logic                   fifo_empty;
    logic [EW-1:0]          head;
    logic [AW-1:0]          head_addr;
    logic [DW-1:0]          head_data;

    logic                   wr_issue;
    logic [AW-1:0]          wr_addr;
    logic [DW-1:0]          wr_data;

    px_fifo #(
        .W          (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_wr),
        .push_dat ({in_addr, in_data}),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (in_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    assign {head_addr, head_data} = head;
    assign clr_busy = (state != IDLE);

    // pend snapshots the occupancy at clear acceptance so that writes pushed
    // after the request are held until the clear has painted the screen.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        pend_nxt    = pend;
        latch_col   = 1'b0;
        fifo_pop    = 1'b0;
        wr_issue    = 1'b0;
        wr_addr     = head_addr;
        wr_data     = head_data;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    latch_col = 1'b1;
                    pend_nxt  = count;
                    state_nxt = CLR_WAIT;
                end else if (mem_en && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_issue = 1'b1;
                end
            end
            CLR_WAIT: begin
                if (pend == '0) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = CLR_RUN;
                end else if (mem_en) begin
                    fifo_pop = 1'b1;
                    wr_issue = 1'b1;
                    pend_nxt = pend - 1'b1;
                end
            end
            CLR_RUN: begin
                if (mem_en) begin
                    wr_issue = 1'b1;
                    wr_addr  = AW'(clr_cnt);
                    wr_data  = clr_col;
                    if (clr_cnt == CW'(NPIX - 1)) begin
                        clr_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            pend    <= '0;
            clr_col <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            pend    <= pend_nxt;
            if (latch_col)
                clr_col <= clr_color;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            ovf      <= 1'b0;
        end else begin
            mem_wr <= wr_issue;
            if (wr_issue) begin
                mem_addr <= wr_addr;
                mem_data <= wr_data;
            end
            if (in_wr && in_full)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_px_write_buffer.sv
// Self-checking bench for px_write_buffer: vector table plus write-order scoreboard.
// Latency: n/a. Backpressure: exercised via mem_en gating and FIFO overflow.
module tb_px_write_buffer;

    localparam int AW   = 15;
    localparam int DW   = 3;
    localparam int DL   = 4;
    localparam int NPIX = 12288;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   in_addr;
    logic [DW-1:0]   in_data;
    logic            in_wr;
    logic            in_full;
    logic            ovf;
    logic [DL:0]     count;
    logic            clr_req;
    logic [DW-1:0]   clr_color;
    logic            clr_busy;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_wr;

    always #5 clk = ~clk;

    px_write_buffer #(
        .AW         (AW),
        .DW         (DW),
        .DEPTH_LOG2 (DL),
        .NPIX       (NPIX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_wr     (in_wr),
        .in_full   (in_full),
        .ovf       (ovf),
        .count     (count),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wr    (mem_wr)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          en;
        logic          acc;
        logic [DL:0]   exp_count;
        logic          exp_full;
        logic          exp_ovf;
        logic          exp_mwr;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic en_q  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_add(input int a, input logic [DW-1:0] d, input logic b);
        exp_t e;
        e.addr = AW'(a);
        e.data = d;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic push_clear(input logic [DW-1:0] c);
        for (int a = 0; a < NPIX; a++)
            sb_add(a, c, (a != NPIX - 1));
    endtask

    task automatic wait_idle(input string name, input int budget, input bit toggle);
        int n = 0;
        while ((clr_busy || sb.size() != 0) && n < budget) begin
            if (toggle)
                mem_en = ~mem_en;
            step();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    always @(posedge clk) en_q <= mem_en;

    // Every framebuffer write must match the head of the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mem_wr) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr: got addr=%0d data=%0d want no write", mem_addr, mem_data);
            end else begin
                e = sb.pop_front();
                chk("wr_stream", 32'({mem_addr, mem_data, clr_busy}), 32'(e));
            end
            chk("wr_gated_by_en", 32'(en_q), 32'd1);
        end
    end

    vec_t vt[20];

    initial begin
        int n;
        bit found;

        rst = 1'b1; in_addr = '0; in_data = '0; in_wr = 1'b0;
        clr_req = 1'b0; clr_color = '0; mem_en = 1'b0;

        // Vector table: fill FIFO with grant withheld, overflow, then pop/push at full.
        for (int i = 0; i < 16; i++)
            vt[i] = '{1'b1, AW'(200 + i), DW'(i), 1'b0, 1'b1, (DL+1)'(i + 1), (i == 15), 1'b0, 1'b0};
        vt[16] = '{1'b1, AW'(999), 3'd7, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0};
        vt[17] = '{1'b1, AW'(998), 3'd6, 1'b1, 1'b0, 5'd15, 1'b0, 1'b1, 1'b1};
        vt[18] = '{1'b1, AW'(300), 3'd5, 1'b1, 1'b1, 5'd15, 1'b0, 1'b1, 1'b1};
        vt[19] = '{1'b0, AW'(0),   3'd0, 1'b0, 1'b0, 5'd15, 1'b0, 1'b1, 1'b0};

        #3;
        chk("rst_in_full",  32'(in_full),  32'd0);
        chk("rst_ovf",      32'(ovf),      32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_mem_wr",   32'(mem_wr),   32'd0);
        #9 rst = 1'b0;
        step();

        // Single write with grant held.
        mem_en = 1'b1;
        in_wr = 1'b1; in_addr = AW'(10175); in_data = 3'b010;
        sb_add(10175, 3'b010, 1'b0);
        step();
        in_wr = 1'b0;
        chk("single_count_after_push", 32'(count),  32'd1);
        chk("single_no_bypass",        32'(mem_wr), 32'd0);
        step();
        chk("single_mem_wr",   32'(mem_wr),   32'd1);
        chk("single_mem_addr", 32'(mem_addr), 32'd10175);
        chk("single_mem_data", 32'(mem_data), 32'd2);
        chk("single_count",    32'(count),    32'd0);
        mem_en = 1'b0;
        step();

        for (int i = 0; i < 20; i++) begin
            in_wr = vt[i].wr; in_addr = vt[i].addr; in_data = vt[i].data; mem_en = vt[i].en;
            if (vt[i].acc)
                sb_add(int'(vt[i].addr), vt[i].data, 1'b0);
            step();
            chk($sformatf("vec%0d_count", i),   32'(count),   32'(vt[i].exp_count));
            chk($sformatf("vec%0d_in_full", i), 32'(in_full), 32'(vt[i].exp_full));
            chk($sformatf("vec%0d_ovf", i),     32'(ovf),     32'(vt[i].exp_ovf));
            chk($sformatf("vec%0d_mem_wr", i),  32'(mem_wr),  32'(vt[i].exp_mwr));
        end
        in_wr = 1'b0; mem_en = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin step(); n++; end
        chk("bp_drain_in_time", 32'(n < 100), 32'd1);
        chk("bp_ovf_sticky",    32'(ovf),     32'd1);
        chk("bp_count_empty",   32'(count),   32'd0);
        mem_en = 1'b0;
        step();

        // Clear after three queued writes drain.
        for (int i = 0; i < 3; i++) begin
            in_wr = 1'b1; in_addr = AW'(50 + i); in_data = DW'(i + 4);
            sb_add(50 + i, DW'(i + 4), 1'b1);
            step();
        end
        in_wr = 1'b0;
        clr_req = 1'b1; clr_color = 3'b001;
        push_clear(3'b001);
        step();
        clr_req = 1'b0;
        chk("clr1_busy",  32'(clr_busy), 32'd1);
        chk("clr1_count", 32'(count),    32'd3);
        mem_en = 1'b1;
        wait_idle("clr1_done", 20000, 1'b0);
        chk("clr1_busy_low", 32'(clr_busy), 32'd0);
        mem_en = 1'b0;
        step();

        // Push during clear with a gated grant; the push must follow address NPIX-1.
        clr_req = 1'b1; clr_color = 3'b110;
        push_clear(3'b110);
        step();
        clr_req = 1'b0;
        step();
        in_wr = 1'b1; in_addr = AW'(6080); in_data = 3'b111;
        sb_add(6080, 3'b111, 1'b0);
        step();
        in_wr = 1'b0;
        chk("clr2_push_count", 32'(count),  32'd1);
        chk("clr2_no_wr_gated", 32'(mem_wr), 32'd0);
        wait_idle("clr2_done", 40000, 1'b1);
        chk("clr2_count_empty", 32'(count), 32'd0);
        mem_en = 1'b0;
        step();

        // Reset mid-clear at counter 5000.
        mem_en = 1'b1;
        clr_req = 1'b1; clr_color = 3'b011;
        push_clear(3'b011);
        step();
        clr_req = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 10000) begin
            step();
            n++;
            if (mem_wr && mem_addr == AW'(4999))
                found = 1'b1;
        end
        chk("rc_reached_4999", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rc_mem_wr",   32'(mem_wr),   32'd0);
        chk("rc_mem_addr", 32'(mem_addr), 32'd0);
        chk("rc_mem_data", 32'(mem_data), 32'd0);
        chk("rc_clr_busy", 32'(clr_busy), 32'd0);
        chk("rc_count",    32'(count),    32'd0);
        chk("rc_in_full",  32'(in_full),  32'd0);
        chk("rc_ovf",      32'(ovf),      32'd0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        mem_en = 1'b0;
        in_wr = 1'b1; in_addr = AW'(77); in_data = 3'b101;
        sb_add(77, 3'b101, 1'b1);
        step();
        in_wr = 1'b0;
        chk("rc_first_push", 32'(count), 32'd1);
        clr_req = 1'b1; clr_color = 3'b101; mem_en = 1'b1;
        push_clear(3'b101);
        step();
        clr_req = 1'b0;
        chk("rc_restart_busy", 32'(clr_busy), 32'd1);
        repeat (100) step();
        clr_req = 1'b1; clr_color = 3'b010;
        repeat (3) step();
        clr_req = 1'b0;
        wait_idle("rc_clear_done", 20000, 1'b0);
        repeat (20) step();
        chk("rc_final_busy", 32'(clr_busy),  32'd0);
        chk("rc_sb_empty",   32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
